// File: rtl/deser_multi_gen.sv
// Ready/valid deserializer: groups 1..MAX_COUNT serial beats into one wide word,
// with a per-group selectable ratio, early close on last_in and a registered output stage.
module deser_multi_gen #(
   parameter int unsigned SER_WIDTH = 16,
   parameter int unsigned NUM_MODES = 4,
   parameter int unsigned COUNT_TABLE [NUM_MODES] = '{1, 2, 4, 8},
   parameter int unsigned MAX_COUNT = 8,
   localparam int unsigned MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
   localparam int unsigned CW = $clog2(MAX_COUNT + 1),
   localparam int unsigned OW = SER_WIDTH * MAX_COUNT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [MW-1:0]        mode_sel,
   input  logic [SER_WIDTH-1:0] serial_in,
   input  logic                 last_in,
   input  logic                 valid_in,
   output logic                 ready_out,
   output logic [OW-1:0]        parallel_out,
   output logic [CW-1:0]        beats_out,
   output logic [MW-1:0]        mode_out,
   output logic                 valid_out,
   input  logic                 ready_in
);

   localparam int unsigned IW = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;

   logic [CW-1:0]        cnt, cnt_d;
   logic [MW-1:0]        mode_q, mode_d, idx_c;
   logic [SER_WIDTH-1:0] slot [MAX_COUNT];
   logic                 would_close_c, acc_c, close_c, pop_c;
   logic [OW-1:0]        word_c, data_d;
   logic [CW-1:0]        beats_d;
   logic [MW-1:0]        mode_out_d;
   logic                 valid_d;

   // Mode is taken from mode_sel only on the first beat; out-of-range maps to mode 0
   always_comb begin
      idx_c = mode_q;
      if (cnt == '0) begin
         idx_c = (32'(mode_sel) < NUM_MODES) ? mode_sel : '0;
      end
   end

   always_comb begin
      would_close_c = last_in | ((32'(cnt) + 32'd1) == COUNT_TABLE[idx_c]);
   end

   // Only a closing beat can stall, and only against a full output that is not draining
   assign ready_out = ~(valid_in & would_close_c) | ~valid_out | ready_in;

   always_comb begin
      acc_c   = valid_in & ready_out;
      close_c = acc_c & would_close_c;
      pop_c   = valid_out & ready_in;
   end

   // Assemble stored beats plus the closing beat; slots past the closing beat are zero
   always_comb begin
      word_c = '0;
      for (int unsigned i = 0; i < MAX_COUNT; i++) begin
         if (i < 32'(cnt)) begin
            word_c[i*SER_WIDTH +: SER_WIDTH] = slot[IW'(i)];
         end else if (i == 32'(cnt)) begin
            word_c[i*SER_WIDTH +: SER_WIDTH] = serial_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (acc_c && !close_c) begin
         slot[cnt[IW-1:0]] <= serial_in;
      end
   end

   always_comb begin
      cnt_d      = cnt;
      mode_d     = mode_q;
      data_d     = parallel_out;
      beats_d    = beats_out;
      mode_out_d = mode_out;
      valid_d    = valid_out;
      if (acc_c && (cnt == '0)) begin
         mode_d = idx_c;
      end
      if (close_c) begin
         cnt_d      = '0;
         data_d     = word_c;
         beats_d    = cnt + CW'(1);
         mode_out_d = idx_c;
         valid_d    = 1'b1;
      end else begin
         if (acc_c) begin
            cnt_d = cnt + CW'(1);
         end
         if (pop_c) begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt          <= '0;
         mode_q       <= '0;
         parallel_out <= '0;
         beats_out    <= '0;
         mode_out     <= '0;
         valid_out    <= 1'b0;
      end else begin
         cnt          <= cnt_d;
         mode_q       <= mode_d;
         parallel_out <= data_d;
         beats_out    <= beats_d;
         mode_out     <= mode_out_d;
         valid_out    <= valid_d;
      end
   end

endmodule
